// File: rtl/jt053246_pkg.sv
// Shared definitions for the object table scanner.
//   - entry word bit positions for word 0 (sub 0) and word 5 (sub 1, w2)
//   - req_t: one 16-pixel column draw request as stored in the FIFO
//   - state_t: scanner FSM states
package jt053246_pkg;

   // Word 0 (sub 0, w0)
   localparam int W0_ACTIVE = 15;
   localparam int W0_SQ     = 14;
   localparam int W0_VFLIP  = 13;
   localparam int W0_HFLIP  = 12;
   localparam int W0_VSZ    = 10;   // [11:10]
   localparam int W0_HSZ    = 8;    // [9:8]

   // Word 5 (sub 1, w2): {res2, shd, attr}
   localparam int W5_ATTR   = 0;    // [9:0]
   localparam int W5_SHD    = 10;   // [11:10]

   typedef struct packed {
      logic [15:0] code;
      logic [8:0]  hpos;
      logic [3:0]  ysub;
      logic [9:0]  hzoom;
      logic [9:0]  attr;
      logic [1:0]  shd;
      logic        hflip;
      logic        vflip;
      logic        first;
   } req_t;

   typedef enum logic [2:0] {IDLE, RD0, RD1, CALC, EMIT, NEXT} state_t;

   // Tile row goes into the interleaved odd code bits, column into the even ones.
   function automatic logic [15:0] merge_code(input logic [15:0] code,
                                              input logic [2:0]  row,
                                              input logic [2:0]  col);
      logic [2:0] r, c;
      r = {code[5], code[3], code[1]} + row;
      c = {code[4], code[2], code[0]} + col;
      return {code[15:6], r[2], c[2], r[1], c[1], r[0], c[0]};
   endfunction

endpackage

// File: rtl/jt053246_reqfifo.sv
// Synchronous FIFO for draw requests.
//   clk, rst (async, active-high), cen : clocking
//   push/din  : write side, accepted when not full or when a pop frees a slot
//   pop/dout  : read side, dout is the head (valid while !empty)
//   full/empty: occupancy flags
module jt053246_reqfifo #(
   parameter int DW = 8,
   parameter int AW = 3
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign empty   = cnt == '0;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign do_pop  = cen && pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign do_push = cen && push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/jt053246_objscan.sv
// Sprite table scanner: on each hs rising edge inside [vfirst,vlast] walks the
// 2^OBJW-entry object table, tests each object against the latched line and
// queues one request per 16-pixel column into a FIFO drained by the drawer.
//   clk, rst (async, active-high), cen : clocking
//   hs, vdump, vfirst, vlast           : scan start and line window
//   ghf, gvf, xoff                     : global flips and X offset
//   tbl_addr/tbl_data                  : object table port ({obj,sub}, 1-cycle latency)
//   req_*                              : FIFO head, valid/ready handshake
//   ovf                                : per-line object cap reached
//   late                               : previous scan still running at start
module jt053246_objscan
   import jt053246_pkg::*;
#(
   parameter int         OBJW   = 8,
   parameter int         FIFOW  = 3,
   parameter int         MAXOBJ = 64,
   parameter logic [9:0] YOFF   = 10'h10F
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            cen,
   input  logic            hs,
   input  logic [8:0]      vdump,
   input  logic [8:0]      vfirst,
   input  logic [8:0]      vlast,
   input  logic            ghf,
   input  logic            gvf,
   input  logic [9:0]      xoff,
   output logic [OBJW+1:0] tbl_addr,
   input  logic [63:0]     tbl_data,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [15:0]     req_code,
   output logic [8:0]      req_hpos,
   output logic [3:0]      req_ysub,
   output logic [9:0]      req_hzoom,
   output logic [9:0]      req_attr,
   output logic [1:0]      req_shd,
   output logic            req_hflip,
   output logic            req_vflip,
   output logic            req_first,
   output logic            ovf,
   output logic            late
);
   localparam int CNTW = OBJW + 1;

   state_t          st, st_nx;
   logic            hs_l, start, push, full, empty, can_push;
   logic [8:0]      vline;
   logic [OBJW-1:0] scan_obj;
   logic [CNTW-1:0] count;
   logic [2:0]      col;
   logic            cap_hit;

   // sub-0 fields
   logic        sq, pre_vf, pre_hf;
   logic [1:0]  vsz, hsz;
   logic [15:0] code;
   logic [9:0]  y, x;
   // CALC results
   logic [9:0]  hzoom_r, attr_r;
   logic [1:0]  shd_r;
   logic [2:0]  row_r;
   logic [3:0]  ysub_r;
   logic        vf_eff_r, hf_eff_r;
   logic [8:0]  xo_r;

   logic [9:0]  vzoom, hzoom, yv, dy, sc, height, xo;
   logic [19:0] prod;
   logic        inzone, visible, vf_eff;
   logic [2:0]  vmask, hmask, row, colx;
   logic [3:0]  ysub;
   req_t        req_in, head;
   logic        unused_bits;

   assign unused_bits = ^{tbl_data[63:58], tbl_data[47:44], prod[5:0]};

   assign start    = cen && hs && !hs_l && vdump >= vfirst && vdump <= vlast;
   assign tbl_addr = {scan_obj, 1'b0, st == RD1};
   assign cap_hit  = (MAXOBJ != 0) && (count == CNTW'(MAXOBJ));
   assign can_push = !full || (req_ready && !empty);

   // Vertical zone test, evaluated while sub 1 is on tbl_data
   always_comb begin
      vzoom   = tbl_data[25:16];
      hzoom   = sq ? vzoom : tbl_data[9:0];
      yv      = (gvf ? -y : y) + YOFF;
      dy      = {vline[8], vline} - yv;
      prod    = {10'd0, dy} * {10'd0, vzoom};
      sc      = prod[15:6];
      height  = 10'd16 << vsz;
      inzone  = !dy[9] && sc < height && prod[19:16] == 4'd0;
      xo      = (ghf ? -x : x) - xoff;
      visible = inzone && !xo[9];
      vf_eff  = pre_vf ^ gvf;
      vmask   = 3'b111 >> (2'd3 - vsz);
      row     = (sc[6:4] ^ {3{vf_eff}}) & vmask;
      ysub    = sc[3:0] ^ {4{vf_eff}};
   end

   // Column request assembly
   always_comb begin
      hmask         = 3'b111 >> (2'd3 - hsz);
      colx          = col ^ (hf_eff_r ? hmask : 3'd0);
      req_in.code   = merge_code(code, row_r, colx);
      req_in.hpos   = xo_r + {2'b00, col, 4'b0000};
      req_in.ysub   = ysub_r;
      req_in.hzoom  = hzoom_r;
      req_in.attr   = attr_r;
      req_in.shd    = shd_r;
      req_in.hflip  = hf_eff_r;
      req_in.vflip  = vf_eff_r;
      req_in.first  = col == 3'd0;
   end

   always_comb begin
      st_nx = st;
      push  = 1'b0;
      case (st)
         IDLE: st_nx = IDLE;
         RD0:  st_nx = RD1;
         RD1:  st_nx = tbl_data[W0_ACTIVE] ? CALC : NEXT;
         CALC: begin
            if (!visible)    st_nx = NEXT;
            else if (cap_hit) st_nx = IDLE;
            else              st_nx = EMIT;
         end
         EMIT: begin
            if (can_push) begin
               push = 1'b1;
               if (col == hmask) st_nx = NEXT;
            end
         end
         NEXT:    st_nx = (scan_obj == {OBJW{1'b1}}) ? IDLE : RD0;
         default: st_nx = IDLE;
      endcase
      if (start) st_nx = RD0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= IDLE;
         hs_l     <= 1'b0;
         vline    <= '0;
         scan_obj <= '0;
         count    <= '0;
         col      <= '0;
         ovf      <= 1'b0;
         late     <= 1'b0;
      end else if (cen) begin
         st   <= st_nx;
         hs_l <= hs;
         if (start) begin
            vline    <= vdump;
            scan_obj <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            late     <= st != IDLE;
         end else begin
            case (st)
               CALC: begin
                  col <= 3'd0;
                  if (visible) begin
                     if (cap_hit) ovf <= 1'b1;
                     else         count <= count + CNTW'(1);
                  end
               end
               EMIT:    if (can_push) col <= col + 3'd1;
               NEXT:    scan_obj <= scan_obj + OBJW'(1);
               default: ;
            endcase
         end
      end
   end

   // Capture stage: sub 0 in RD1, sub 1 derived values in CALC
   always_ff @(posedge clk) begin
      if (cen) begin
         if (st == RD1) begin
            sq     <= tbl_data[W0_SQ];
            pre_vf <= tbl_data[W0_VFLIP];
            pre_hf <= tbl_data[W0_HFLIP];
            vsz    <= tbl_data[W0_VSZ +: 2];
            hsz    <= tbl_data[W0_HSZ +: 2];
            code   <= tbl_data[31:16];
            y      <= tbl_data[41:32];
            x      <= tbl_data[57:48];
         end
         if (st == CALC) begin
            hzoom_r  <= hzoom;
            attr_r   <= tbl_data[32 + W5_ATTR +: 10];
            shd_r    <= tbl_data[32 + W5_SHD +: 2];
            row_r    <= row;
            ysub_r   <= ysub;
            vf_eff_r <= vf_eff;
            hf_eff_r <= pre_hf ^ ghf;
            xo_r     <= xo[8:0];
         end
      end
   end

   jt053246_reqfifo #(.DW($bits(req_t)), .AW(FIFOW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .cen   (cen),
      .push  (push),
      .din   (req_in),
      .pop   (req_ready),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // Head fields read as zero while the FIFO is empty
   assign req_valid = !empty;
   assign req_code  = req_valid ? head.code  : '0;
   assign req_hpos  = req_valid ? head.hpos  : '0;
   assign req_ysub  = req_valid ? head.ysub  : '0;
   assign req_hzoom = req_valid ? head.hzoom : '0;
   assign req_attr  = req_valid ? head.attr  : '0;
   assign req_shd   = req_valid ? head.shd   : '0;
   assign req_hflip = req_valid && head.hflip;
   assign req_vflip = req_valid && head.vflip;
   assign req_first = req_valid && head.first;

endmodule

// File: tb/tb_jt053246_objscan.sv
module tb_jt053246_objscan;
   import jt053246_pkg::*;

   logic        clk = 1'b0, rst = 1'b1, cen = 1'b1, hs = 1'b0;
   logic        ghf = 1'b0, gvf = 1'b0, req_ready = 1'b1;
   logic [8:0]  vdump = 9'd0, vfirst = 9'h105, vlast = 9'h105;
   logic [9:0]  xoff = 10'h010;
   logic [9:0]  tbl_addr;
   logic [63:0] tbl_data;
   logic        req_valid, req_hflip, req_vflip, req_first, ovf, late;
   logic [15:0] req_code;
   logic [8:0]  req_hpos;
   logic [3:0]  req_ysub;
   logic [9:0]  req_hzoom, req_attr;
   logic [1:0]  req_shd;

   logic [63:0] mem [0:1023];
   req_t        exp_q[$];
   req_t        act, expv;
   int          total = 0, bad = 0;
   logic [15:0] colofs [8] = '{16'h00, 16'h01, 16'h04, 16'h05,
                               16'h10, 16'h11, 16'h14, 16'h15};

   jt053246_objscan #(.OBJW(8), .FIFOW(3), .MAXOBJ(2), .YOFF(10'h10F)) dut (
      .clk(clk), .rst(rst), .cen(cen), .hs(hs), .vdump(vdump), .vfirst(vfirst),
      .vlast(vlast), .ghf(ghf), .gvf(gvf), .xoff(xoff), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .req_valid(req_valid), .req_ready(req_ready),
      .req_code(req_code), .req_hpos(req_hpos), .req_ysub(req_ysub),
      .req_hzoom(req_hzoom), .req_attr(req_attr), .req_shd(req_shd),
      .req_hflip(req_hflip), .req_vflip(req_vflip), .req_first(req_first),
      .ovf(ovf), .late(late)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (cen) tbl_data <= mem[tbl_addr];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
   endtask

   task automatic put_obj(input int obj, input logic [15:0] w0, input logic [15:0] code,
                          input logic [9:0] y, input logic [9:0] x, input logic [9:0] vz,
                          input logic [9:0] hz, input logic [13:0] w5);
      mem[obj*4]   = {6'd0, x, 6'd0, y, code, w0};
      mem[obj*4+1] = {16'd0, 2'd0, w5, 6'd0, vz, 6'd0, hz};
   endtask

   task automatic expect_req(input logic [15:0] code, input logic [8:0] hpos,
                             input logic [3:0] ysub, input logic [9:0] hz,
                             input logic [9:0] attr, input logic [1:0] shd,
                             input logic hf, input logic vf, input logic first);
      req_t r;
      r.code = code; r.hpos = hpos; r.ysub = ysub; r.hzoom = hz; r.attr = attr;
      r.shd = shd; r.hflip = hf; r.vflip = vf; r.first = first;
      exp_q.push_back(r);
   endtask

   // Returns 1 ns after the clock edge on which the start is sampled
   task automatic start_line(input logic [8:0] vd);
      @(posedge clk); #1;
      vdump = vd;
      hs    = 1'b1;
      @(posedge clk); #1;
      hs    = 1'b0;
   endtask

   task automatic wait_scan(input string name);
      repeat (1200) @(posedge clk);
      #1;
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      clear_mem();
      fork
         forever begin
            @(negedge clk);
            if (!rst && cen && req_valid && req_ready) begin
               act.code = req_code; act.hpos = req_hpos; act.ysub = req_ysub;
               act.hzoom = req_hzoom; act.attr = req_attr; act.shd = req_shd;
               act.hflip = req_hflip; act.vflip = req_vflip; act.first = req_first;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_req: got %h want none", act);
               end else begin
                  expv = exp_q.pop_front();
                  check("req", 64'(act), 64'(expv));
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(req_valid), 64'd0);
      check("rst_code",  64'(req_code),  64'd0);
      check("rst_addr",  64'(tbl_addr),  64'd0);
      check("rst_ovf",   64'(ovf),       64'd0);
      check("rst_late",  64'(late),      64'd0);
      rst = 1'b0;

      // 1:1 object, two columns (dy=5)
      put_obj(3, 16'h8100, 16'h1000, 10'h1F1, 10'h050, 10'h040, 10'h040, 14'h08A5);
      expect_req(16'h1000, 9'h040, 4'd5, 10'h040, 10'h0A5, 2'd2, 1'b0, 1'b0, 1'b1);
      expect_req(16'h1001, 9'h050, 4'd5, 10'h040, 10'h0A5, 2'd2, 1'b0, 1'b0, 1'b0);
      start_line(9'h105);
      check("late_first", 64'(late), 64'd0);
      wait_scan("drain_basic");

      // 2x vertical zoom, out-of-zone object, square zoom
      clear_mem();
      put_obj(0, 16'h8400, 16'h1000, 10'h1EC, 10'h050, 10'h080, 10'h020, 14'h0003);
      put_obj(1, 16'h8000, 16'h2000, 10'h1EE, 10'h050, 10'h080, 10'h020, 14'h0000);
      put_obj(2, 16'hC000, 16'h3000, 10'h1F1, 10'h060, 10'h040, 10'h077, 14'h0011);
      expect_req(16'h1002, 9'h040, 4'd4, 10'h020, 10'h003, 2'd0, 1'b0, 1'b0, 1'b1);
      expect_req(16'h3000, 9'h050, 4'd5, 10'h040, 10'h011, 2'd0, 1'b0, 1'b0, 1'b1);
      start_line(9'h105);
      wait_scan("drain_zoom");

      // Object flips: row inverted, columns reversed
      clear_mem();
      put_obj(5, 16'hB500, 16'h2000, 10'h1F3, 10'h050, 10'h040, 10'h040, 14'h0C00);
      expect_req(16'h2003, 9'h040, 4'd12, 10'h040, 10'h000, 2'd3, 1'b1, 1'b1, 1'b1);
      expect_req(16'h2002, 9'h050, 4'd12, 10'h040, 10'h000, 2'd3, 1'b1, 1'b1, 1'b0);
      start_line(9'h105);
      wait_scan("drain_flip");

      // Object cap of 2 with five visible objects
      clear_mem();
      for (int i = 10; i < 15; i++)
         put_obj(i, 16'h8000, 16'(i << 8), 10'h1F1, 10'h050, 10'h040, 10'h040, 14'h0000);
      expect_req(16'h0A00, 9'h040, 4'd5, 10'h040, 10'h000, 2'd0, 1'b0, 1'b0, 1'b1);
      expect_req(16'h0B00, 9'h040, 4'd5, 10'h040, 10'h000, 2'd0, 1'b0, 1'b0, 1'b1);
      start_line(9'h105);
      wait_scan("drain_cap");
      check("ovf_set", 64'(ovf), 64'd1);

      // Backpressure: two 8-column objects against an 8-deep FIFO
      clear_mem();
      req_ready = 1'b0;
      put_obj(20, 16'h8300, 16'h4000, 10'h1F1, 10'h050, 10'h040, 10'h040, 14'h0000);
      put_obj(21, 16'h8300, 16'h5000, 10'h1F1, 10'h050, 10'h040, 10'h040, 14'h0000);
      for (int o = 0; o < 2; o++)
         for (int c = 0; c < 8; c++)
            expect_req((o == 0 ? 16'h4000 : 16'h5000) + colofs[c], 9'(9'h040 + 16*c),
                       4'd5, 10'h040, 10'h000, 2'd0, 1'b0, 1'b0, c == 0);
      start_line(9'h105);
      check("ovf_clear", 64'(ovf), 64'd0);
      repeat (1200) @(posedge clk);
      #1;
      check("bp_valid", 64'(req_valid), 64'd1);
      check("bp_stall_addr", 64'(tbl_addr), 64'd84);
      req_ready = 1'b1;
      wait_scan("drain_bp");
      check("bp_empty", 64'(req_valid), 64'd0);

      // Late scan: restart while stalled in EMIT of object 1
      clear_mem();
      req_ready = 1'b0;
      put_obj(0, 16'h8300, 16'h4000, 10'h1F1, 10'h050, 10'h040, 10'h040, 14'h0000);
      put_obj(1, 16'h8300, 16'h5000, 10'h1F1, 10'h050, 10'h040, 10'h040, 14'h0000);
      for (int o = 0; o < 3; o++)
         for (int c = 0; c < 8; c++)
            expect_req((o == 2 ? 16'h5000 : 16'h4000) + colofs[c], 9'(9'h040 + 16*c),
                       4'd5, 10'h040, 10'h000, 2'd0, 1'b0, 1'b0, c == 0);
      start_line(9'h105);
      repeat (200) @(posedge clk);
      #1;
      check("late_stall_addr", 64'(tbl_addr), 64'd4);
      start_line(9'h105);
      check("late_set", 64'(late), 64'd1);
      check("late_restart_addr", 64'(tbl_addr), 64'd0);
      req_ready = 1'b1;
      wait_scan("drain_late");

      // Asynchronous reset in the middle of EMIT
      req_ready = 1'b0;
      start_line(9'h105);
      check("late_clear", 64'(late), 64'd0);
      repeat (200) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_mid_valid", 64'(req_valid), 64'd0);
      check("rst_mid_addr",  64'(tbl_addr),  64'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      req_ready = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      check("rst_idle_valid", 64'(req_valid), 64'd0);
      check("rst_idle_addr",  64'(tbl_addr),  64'd0);

      // hs outside [vfirst,vlast] does not start a scan
      clear_mem();
      put_obj(0, 16'h8000, 16'h7000, 10'h2F1, 10'h050, 10'h040, 10'h040, 14'h0000);
      start_line(9'h005);
      repeat (5) @(posedge clk);
      #1;
      check("range_addr", 64'(tbl_addr), 64'd0);
      wait_scan("drain_range");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jt053246_objscan.md
Name: jt053246_objscan

Overview:
- Parametrised successor of the K053246 sprite table scanner.
- Walks an object table of 2^OBJW entries once per line, evaluates vertical zoom and zone, and splits each visible object into 16-pixel column draw requests.
- Pushes requests into an internal FIFO drained by the line-buffer drawer with a valid/ready handshake, so the scan is decoupled from draw timing.
- Adds a per-line object cap with an overflow flag, and a late-scan flag.

Parameters:
- OBJW, 8, log2 of object table entries (256 objects).
- FIFOW, 3, log2 of request FIFO depth (8 entries).
- MAXOBJ, 64, maximum visible objects accepted per line; 0 = unlimited.
- YOFF, 10'h10F, constant added to object Y before the zone test.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cen  in  1  clock enable; all state advances only when cen=1
- hs  in  1  horizontal sync; rising edge starts a scan
- vdump  in  9  current line; latched at scan start
- vfirst  in  9  first active line for scanning (inclusive)
- vlast  in  9  last active line for scanning (inclusive)
- ghf, gvf  in  1 each  global horizontal/vertical flip
- xoff  in  10  X offset, subtracted from object X
- tbl_addr  out  OBJW+2  object table word address {obj,sub}
- tbl_data  in  64  {w3,w2,w1,w0}, valid 1 cen-cycle after tbl_addr
- req_valid  out  1  FIFO head valid
- req_ready  in  1  drawer accepts head
- req_code  out  16  tile code with row/column bits merged
- req_hpos  out  9  column X position
- req_ysub  out  4  line within 16-pixel tile
- req_hzoom  out  10  horizontal zoom
- req_attr  out  10  colour/priority attributes
- req_shd  out  2  shadow bits
- req_hflip, req_vflip  out  1 each  effective flips
- req_first  out  1  first column of an object
- ovf  out  1  cap reached on the current line
- late  out  1  previous scan had not finished at hs

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; scan_obj 0.
- Start condition: hs rising edge with vfirst<=vdump<=vlast, checked on a cen cycle. Action: latch vline=vdump, scan_obj=0, ovf=0, count=0.
  - If the FSM is not in IDLE at that point, late=1 for the new line and the scan restarts immediately.
  - FIFO contents are kept.
- Entry word layout:
  - w0: [15] active, [14] sq, [13] vflip, [12] hflip, [11:10] vsz, [9:8] hsz.
  - w1: code.
  - w2: [9:0] y.
  - w3: [9:0] x.
  - Word 4 of the entry: {vzoom, hzoom}, read with sub=1 as {w1,w0}. When sq=1, hzoom=vzoom.
  - Word 5 of the entry: [13:0] {res2, shd, attr}, read with sub=1 as w2 low.
  - Only sub 0 and 1 are used.
- FSM states:
  - IDLE: wait for start.
  - RD0: issue sub0.
  - RD1: capture sub0. If not active, go to NEXT; otherwise issue sub1.
  - CALC: capture sub1 and compute.
  - EMIT: push one column per cen cycle while the FIFO is not full.
  - NEXT: scan_obj+1; if scan_obj was the last object, go to IDLE; else go to RD0.
- Vertical arithmetic, 10-bit wrapping:
  - yv = (gvf ? -y : y) + YOFF
  - dy = {vline[8],vline} - yv
  - sc = (dy*vzoom)>>6 (0x40 = 1:1)
  - height = 16<<vsz
  - inzone = !dy[9] && sc<height && product bits above 15 are zero
- Zone outcome: if inzone=0, go to NEXT. If MAXOBJ!=0 and count==MAXOBJ, set ovf=1 and go to IDLE. Otherwise count+1 and go to EMIT.
- Derived values:
  - row = sc[6:4] masked to vsz bits, inverted when vflip_eff.
  - ysub = sc[3:0] ^ {4{vflip_eff}}.
  - vflip_eff = pre_vf^gvf.
  - hflip_eff = pre_hf^ghf.
- Columns: ncol=1<<hsz, col 0..ncol-1.
  - Code bits {code[5],code[3],code[1]} += row; {code[4],code[2],code[0]} += col ^ hflip mask.
  - hpos = ((ghf?-x:x)-xoff)[8:0] + 16*col.
  - req_first=1 on col 0.
  - Objects with X bit 9 set after offset are skipped.
- FIFO: push on EMIT when not full, pop on req_valid&&req_ready. Simultaneous push and pop when full is allowed: occupancy stays unchanged. Full FIFO stalls EMIT; data is never dropped.
- Reset mid-scan: everything returns to reset values in the same cycle (asynchronous).

Decomposition:
- Package jt053246_pkg:
  - entry word field localparams;
  - request struct typedef (code, hpos, ysub, hzoom, attr, shd, flips, first);
  - FSM state enum.
- Sub-module jt053246_reqfifo: parametrised synchronous FIFO with full/empty flags and same-cycle push/pop.

Test Plan:
- Single 1:1 object: y such that yv=0x100, vline=0x105, vsz=0, hsz=1, vzoom=0x40, code 0x1000 -> two requests, codes 0x1000 and 0x1001; ysub=5; hpos x-xoff and +16; req_first 1 then 0.
- Vertical zoom 2x: vzoom=0x80, dy=10 -> sc=20, row 1, ysub 4, code bit1 set; dy=8 with vsz=0 -> out of zone, no request.
- Flip: gvf=0, pre_vf=1, vsz=1, sc=3 -> row 1, ysub 12; pre_hf=1, hsz=1 -> column codes emitted in order +1 then +0.
- Cap: MAXOBJ=2, five visible objects on one line -> exactly two objects' columns queued; ovf=1 until the next start.
- Backpressure: req_ready=0, hsz=3 object with FIFOW=3 -> 8 entries then stall; release ready -> all 8 in order, none lost, FIFO returns to empty.
- Late scan: hs during EMIT -> late=1, scan_obj restarts at 0; rst asserted mid-EMIT -> req_valid=0 immediately, FSM in IDLE.
